// File: rtl/mbus_ext_int_ctrl.sv
// EXTERNAL_INT request generator for the MBus wire-control stage: holds a layer interrupt
// until the bus is idle, pulls DOUT low until bus clock edges are seen, then acks.
// Optional abort-on-timeout is enabled by defining MBUS_EXT_INT_TIMEOUT_EN.
module mbus_ext_int_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RELEASE_EDGES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic REQ_INT,
  input  logic BUS_BUSY,
  input  logic CLKIN,
  output logic EXTERNAL_INT,
  output logic REQ_ACK,
  output logic REQ_TIMEOUT
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2..4");
  end
  if (RELEASE_EDGES < 1 || RELEASE_EDGES > 15) begin : g_bad_release_edges
    $error("RELEASE_EDGES must be 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StWaitIdle, StAssert, StRelease} state_e;

  localparam logic [3:0] RelEdges = 4'(RELEASE_EDGES);

  state_e                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   clkin_prev_q;
  logic                   clk_fall;
  logic [3:0]             edge_cnt_q, edge_cnt_d, edge_cnt_inc;
  logic                   release_hit, timeout_hit, abort;
  logic                   ext_int_q, ack_q, timeout_q;

  // Flops reset high: the bus clock idles high, so reset must not look like a falling edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_q       <= '1;
      clkin_prev_q <= 1'b1;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], CLKIN};
      clkin_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_fall     = clkin_prev_q & ~sync_q[SYNC_STAGES-1];
  assign edge_cnt_inc = (edge_cnt_q == 4'hf) ? 4'hf : edge_cnt_q + 4'd1;
  assign release_hit  = clk_fall && (edge_cnt_inc >= RelEdges);

`ifdef MBUS_EXT_INT_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Runs only while staying in ASSERT; any other state leaves it at zero for the next entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StAssert && state_d == StAssert) tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    edge_cnt_d = edge_cnt_q;
    abort      = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d = 1'b0;
          state_d   = BUS_BUSY ? StWaitIdle : StAssert;
        end else if (REQ_INT) begin
          pending_d = 1'b1;
        end
      end
      StWaitIdle: begin
        if (!BUS_BUSY) state_d = StAssert;
      end
      StAssert: begin
        if (clk_fall) edge_cnt_d = edge_cnt_inc;
        // A completing edge outranks a coincident timeout.
        if (release_hit) begin
          state_d = StRelease;
        end else if (timeout_hit) begin
          state_d    = StIdle;
          edge_cnt_d = '0;
          abort      = 1'b1;
        end
      end
      StRelease: begin
        edge_cnt_d = '0;
        state_d    = StIdle;
        if (REQ_INT) pending_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      edge_cnt_q <= '0;
      ext_int_q  <= 1'b0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      edge_cnt_q <= edge_cnt_d;
      ext_int_q  <= (state_d == StAssert);
      ack_q      <= (state_d == StRelease);
      timeout_q  <= abort;
    end
  end

  assign EXTERNAL_INT = ext_int_q;
  assign REQ_ACK      = ack_q;
  assign REQ_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_mbus_ext_int_ctrl.sv
// Scoreboard bench for mbus_ext_int_ctrl: each EXTERNAL_INT episode (high length plus the
// ack/timeout seen as it ends) is matched against a queue of hand-computed expectations.
module tb_mbus_ext_int_ctrl;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic REQ_INT = 1'b0;
  logic BUS_BUSY = 1'b0;
  logic CLKIN = 1'b1;
  logic EXTERNAL_INT, REQ_ACK, REQ_TIMEOUT;

  int total = 0;
  int bad = 0;

  typedef struct {
    int len;
    bit ack;
    bit tmo;
  } obs_t;

  obs_t exp_q[$];
  int   run_len = 0;

  always #5 CLK = ~CLK;

  mbus_ext_int_ctrl #(
    .SYNC_STAGES   (2),
    .RELEASE_EDGES (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .REQ_INT     (REQ_INT),
    .BUS_BUSY    (BUS_BUSY),
    .CLKIN       (CLKIN),
    .EXTERNAL_INT(EXTERNAL_INT),
    .REQ_ACK     (REQ_ACK),
    .REQ_TIMEOUT (REQ_TIMEOUT)
  );

  // Monitor: an episode ends when EXTERNAL_INT is low after being high, or on a stray pulse.
  always @(negedge CLK) begin
    obs_t e;
    if (EXTERNAL_INT === 1'b1) begin
      run_len++;
    end else if (run_len > 0 || REQ_ACK !== 1'b0 || REQ_TIMEOUT !== 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_episode: got len=%0d ack=%b tmo=%b, none expected",
                 run_len, REQ_ACK, REQ_TIMEOUT);
      end else begin
        e = exp_q.pop_front();
        if (run_len != e.len || REQ_ACK !== e.ack || REQ_TIMEOUT !== e.tmo) begin
          bad++;
          $display("FAIL episode: got len=%0d ack=%b tmo=%b, expected len=%0d ack=%b tmo=%b",
                   run_len, REQ_ACK, REQ_TIMEOUT, e.len, e.ack, e.tmo);
        end
      end
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic expect_episode(input int len, input bit ack, input bit tmo);
    obs_t e;
    e.len = len;
    e.ack = ack;
    e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    CLKIN    = 1'b1;
    REQ_INT  = 1'b0;
    BUS_BUSY = 1'b0;
    repeat (6) tick();
  endtask

  // Bus clock at CLK/8: high for 4 cycles, low for 4.
  function automatic logic wave(input int k);
    return ((k % 8) < 4) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    #1;
    check("reset_ext_int", EXTERNAL_INT, 1'b0);
    check("reset_ack", REQ_ACK, 1'b0);
    check("reset_timeout", REQ_TIMEOUT, 1'b0);
    repeat (2) tick();
    RESETn = 1'b1;
    settle();

    // Basic: second fall sampled at k=12 -> released 14 cycles after the rise.
    expect_episode(14, 1'b1, 1'b0);
    REQ_INT = 1'b1;
    tick();
    REQ_INT = 1'b0;
    check("no_rise_yet", EXTERNAL_INT, 1'b0);
    for (int k = 0; k < 24; k++) begin
      CLKIN = wave(k);
      tick();
      if (k == 0) check("rise_basic", EXTERNAL_INT, 1'b1);
    end
    settle();

    // Busy bus holds the request for 20 cycles.
    expect_episode(15, 1'b1, 1'b0);
    BUS_BUSY = 1'b1;
    REQ_INT  = 1'b1;
    tick();
    REQ_INT = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("busy_hold", EXTERNAL_INT, 1'b0);
    end
    BUS_BUSY = 1'b0;
    tick();
    check("rise_after_busy", EXTERNAL_INT, 1'b1);
    for (int k = 0; k < 24; k++) begin
      CLKIN = wave(k);
      tick();
    end
    settle();

    // Requests during ASSERT merge; one in the RELEASE cycle (k=15) starts a second sequence.
    expect_episode(14, 1'b1, 1'b0);
    expect_episode(14, 1'b1, 1'b0);
    REQ_INT = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      CLKIN   = wave(k);
      REQ_INT = (k == 2 || k == 5 || k == 8 || k == 15) ? 1'b1 : 1'b0;
      tick();
      if (k == 14) check("ack_pulse_first", REQ_ACK, 1'b1);
    end
    REQ_INT = 1'b0;
    settle();

`ifdef MBUS_EXT_INT_TIMEOUT_EN
    // CLKIN idle: abort after 16 cycles.
    expect_episode(16, 1'b0, 1'b1);
    REQ_INT = 1'b1;
    tick();
    REQ_INT = 1'b0;
    repeat (24) tick();
    settle();

    // Final fall coincides with the timeout cycle: release wins.
    expect_episode(16, 1'b1, 1'b0);
    REQ_INT = 1'b1;
    tick();
    REQ_INT = 1'b0;
    for (int k = 0; k < 24; k++) begin
      CLKIN = (k < 4 || (k >= 8 && k < 14)) ? 1'b1 : 1'b0;
      tick();
    end
    settle();
`endif

    // Reset mid-ASSERT after one counted edge: drop immediately, no ack.
    expect_episode(8, 1'b0, 1'b0);
    REQ_INT = 1'b1;
    tick();
    REQ_INT = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      CLKIN = wave(k);
      tick();
    end
    RESETn = 1'b0;
    #1;
    check("reset_mid_ext_int", EXTERNAL_INT, 1'b0);
    check("reset_mid_ack", REQ_ACK, 1'b0);
    repeat (3) tick();
    RESETn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      CLKIN = wave(k);
      tick();
    end
    check("post_reset_ext_int", EXTERNAL_INT, 1'b0);
    check("post_reset_ack", REQ_ACK, 1'b0);

    repeat (10) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_episodes: got %0d left over, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
